ctrl_bank_timer: RTL and testbench

- Upstream timing/bank-state stage that feeds the command generator.
- Accepts one host read/write request at a time and tracks the open row of each of 16 banks (4 BG x 4 BA).
- Sequences one-cycle ready pulses (pre_rdy, act_rdy/no_act_rdy, cas_rdy) that respect tRP/tRCD and burst completion.
- Schedules periodic refresh (prea_rdy, refresh_rdy) and drives busy back to the host/decoder.

---
 rtl/ctrl_bank_timer_pkg.sv | 32 +++
 rtl/ctrl_bank_timer_row_table.sv | 51 +++++
 rtl/ctrl_bank_timer.sv | 165 ++++++++++++++++
 tb/tb_ctrl_bank_timer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_bank_timer_pkg.sv
// ctrl_bank_timer_pkg: shared request/address types, bank-timer states and default DDR timings
package ctrl_bank_timer_pkg;

    typedef enum logic [1:0] {RD_R, WR_R, RDA_R, WRA_R} request_type;

    typedef struct packed {
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [13:0] row;
    } mem_addr_type;

    typedef enum logic [3:0] {
        IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, HIT, CAS, DATA_WAIT,
        AP_WAIT, PREA, PREA_WAIT, REF, REF_WAIT
    } bank_state_e;

    localparam int T_RCD_DEF  = 11;
    localparam int T_RP_DEF   = 11;
    localparam int T_WR_DEF   = 12;
    localparam int T_RFC_DEF  = 208;
    localparam int T_REFI_DEF = 6240;
    localparam int CNT_W_DEF  = 13;

    function automatic logic is_wr(request_type t);
        return t == WR_R || t == WRA_R;
    endfunction

    function automatic logic is_ap(request_type t);
        return t == RDA_R || t == WRA_R;
    endfunction

endpackage

// File: rtl/ctrl_bank_timer_row_table.sv
// bank_row_table: open-row register file for 16 banks, indexed by {bg, ba}
//   lk_idx/lk_row  -> lk_valid (bank open), lk_hit (open on lk_row); miss = lk_valid && !lk_hit
//   open_en        -> mark wr_idx open on wr_row
//   close_en       -> mark wr_idx closed
//   clear_all      -> close every bank (wins over open/close)
//   any_open       -> at least one bank open
module bank_row_table (
    input  logic        CK_t,
    input  logic        reset_n,
    input  logic [3:0]  lk_idx,
    input  logic [13:0] lk_row,
    output logic        lk_valid,
    output logic        lk_hit,
    input  logic        open_en,
    input  logic        close_en,
    input  logic        clear_all,
    input  logic [3:0]  wr_idx,
    input  logic [13:0] wr_row,
    output logic        any_open
);

    logic [15:0] valid_q, valid_d;
    logic [13:0] row_q [16];
    logic [13:0] row_d [16];

    always_comb begin
        valid_d = valid_q;
        row_d   = row_q;
        if (open_en) begin
            valid_d[wr_idx] = 1'b1;
            row_d[wr_idx]   = wr_row;
        end
        if (close_en) valid_d[wr_idx] = 1'b0;
        if (clear_all) valid_d = '0;
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            row_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            row_q   <= row_d;
        end
    end

    assign lk_valid = valid_q[lk_idx];
    assign lk_hit   = lk_valid && row_q[lk_idx] == lk_row;
    assign any_open = |valid_q;

endmodule

// File: rtl/ctrl_bank_timer.sv
// ctrl_bank_timer: per-request PRE/ACT/CAS pulse sequencing with open-row tracking and periodic refresh
//   init_done, req_valid, req_type, bg/ba/row_addr : host request interface
//   CL, CWL, AL, BL                                : mode-register latencies used for CAS-to-idle timing
//   busy                                           : request cannot be accepted
//   act_rdy, no_act_rdy, cas_rdy, pre_rdy          : one-cycle request command pulses
//   prea_rdy, refresh_rdy                          : one-cycle refresh command pulses
//   ref_overrun                                    : sticky, a refresh interval expired with refresh still pending
module ctrl_bank_timer
    import ctrl_bank_timer_pkg::*;
#(
    parameter int tRCD  = T_RCD_DEF,
    parameter int tRP   = T_RP_DEF,
    parameter int tWR   = T_WR_DEF,
    parameter int tRFC  = T_RFC_DEF,
    parameter int tREFI = T_REFI_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic        CK_t,
    input  logic        reset_n,
    input  logic        init_done,
    input  logic        req_valid,
    input  logic [1:0]  req_type,
    input  logic [1:0]  bg_addr,
    input  logic [1:0]  ba_addr,
    input  logic [13:0] row_addr,
    input  logic [4:0]  CL,
    input  logic [4:0]  CWL,
    input  logic [4:0]  AL,
    input  logic [3:0]  BL,
    output logic        busy,
    output logic        act_rdy,
    output logic        no_act_rdy,
    output logic        cas_rdy,
    output logic        pre_rdy,
    output logic        prea_rdy,
    output logic        refresh_rdy,
    output logic        ref_overrun
);

    // Wait states exit when the counter reaches 0, so a state entered after
    // a one-cycle command state is loaded with delay-2 to land the next
    // command exactly delay cycles after the previous one.
    localparam logic [CNT_W-1:0] RCD_L  = CNT_W'(tRCD - 2);
    localparam logic [CNT_W-1:0] RP_L   = CNT_W'(tRP - 2);
    localparam logic [CNT_W-1:0] AP_L   = CNT_W'(tRP - 1);
    localparam logic [CNT_W-1:0] RFC_L  = CNT_W'(tRFC - 2);
    localparam logic [CNT_W-1:0] REFI_L = CNT_W'(tREFI);

    bank_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, ref_cnt_q, ref_cnt_d, lat;
    request_type      type_q, type_d;
    mem_addr_type     addr_q, addr_d;
    logic             ref_pending_q, ref_pending_d, ref_overrun_q, ref_overrun_d;
    logic             act_rdy_q, act_rdy_d, no_act_rdy_q, no_act_rdy_d, cas_rdy_q, cas_rdy_d;
    logic             pre_rdy_q, pre_rdy_d, prea_rdy_q, prea_rdy_d, refresh_rdy_q, refresh_rdy_d;
    logic             lk_valid, lk_hit, any_open, cnt_zero, ref_expire, ref_done;

    bank_row_table u_rows (
        .CK_t      (CK_t),
        .reset_n   (reset_n),
        .lk_idx    ({bg_addr, ba_addr}),
        .lk_row    (row_addr),
        .lk_valid  (lk_valid),
        .lk_hit    (lk_hit),
        .open_en   (state_q == ACT),
        .close_en  (state_q == PRE || (state_q == CAS && is_ap(type_q))),
        .clear_all (state_q == PREA),
        .wr_idx    ({addr_q.bg, addr_q.ba}),
        .wr_row    (addr_q.row),
        .any_open  (any_open)
    );

    assign cnt_zero   = cnt_q == '0;
    assign lat        = CNT_W'(AL) + (is_wr(type_q) ? CNT_W'(CWL) + CNT_W'(tWR) : CNT_W'(CL)) + CNT_W'(BL >> 1);
    assign ref_expire = init_done && ref_cnt_q == '0;
    assign ref_done   = state_q == REF_WAIT && cnt_zero;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        type_d  = type_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (ref_pending_q) begin
                    state_d = any_open ? PREA : REF;
                end else if (init_done && req_valid) begin
                    type_d  = request_type'(req_type);
                    addr_d  = '{bg: bg_addr, ba: ba_addr, row: row_addr};
                    state_d = !lk_valid ? ACT : lk_hit ? HIT : PRE;
                end
            end
            PRE:       begin state_d = PRE_WAIT; cnt_d = RP_L; end
            PRE_WAIT:  state_d = cnt_zero ? ACT : PRE_WAIT;
            ACT:       begin state_d = ACT_WAIT; cnt_d = RCD_L; end
            ACT_WAIT:  state_d = cnt_zero ? CAS : ACT_WAIT;
            HIT:       state_d = CAS;
            CAS:       begin state_d = DATA_WAIT; cnt_d = lat - CNT_W'(2); end
            DATA_WAIT: begin
                if (cnt_zero) begin
                    state_d = is_ap(type_q) ? AP_WAIT : IDLE;
                    cnt_d   = AP_L;
                end
            end
            AP_WAIT:   state_d = cnt_zero ? IDLE : AP_WAIT;
            PREA:      begin state_d = PREA_WAIT; cnt_d = RP_L; end
            PREA_WAIT: state_d = cnt_zero ? REF : PREA_WAIT;
            REF:       begin state_d = REF_WAIT; cnt_d = RFC_L; end
            REF_WAIT:  state_d = cnt_zero ? IDLE : REF_WAIT;
            default:   state_d = IDLE;
        endcase
        act_rdy_d     = state_d == ACT;
        no_act_rdy_d  = state_d == HIT;
        cas_rdy_d     = state_d == CAS;
        pre_rdy_d     = state_d == PRE;
        prea_rdy_d    = state_d == PREA;
        refresh_rdy_d = state_d == REF;
        ref_cnt_d     = !init_done ? ref_cnt_q : ref_expire ? REFI_L : ref_cnt_q - 1'b1;
        // a new expiry re-arms the request even in the cycle the previous refresh retires
        ref_pending_d = ref_expire || (ref_pending_q && !ref_done);
        ref_overrun_d = ref_overrun_q || (ref_expire && ref_pending_q);
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            type_q        <= RD_R;
            addr_q        <= '0;
            ref_cnt_q     <= REFI_L;
            ref_pending_q <= 1'b0;
            ref_overrun_q <= 1'b0;
            act_rdy_q     <= 1'b0;
            no_act_rdy_q  <= 1'b0;
            cas_rdy_q     <= 1'b0;
            pre_rdy_q     <= 1'b0;
            prea_rdy_q    <= 1'b0;
            refresh_rdy_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            ref_overrun_q <= ref_overrun_d;
            act_rdy_q     <= act_rdy_d;
            no_act_rdy_q  <= no_act_rdy_d;
            cas_rdy_q     <= cas_rdy_d;
            pre_rdy_q     <= pre_rdy_d;
            prea_rdy_q    <= prea_rdy_d;
            refresh_rdy_q <= refresh_rdy_d;
        end
    end

    assign busy        = !init_done || state_q != IDLE || ref_pending_q;
    assign act_rdy     = act_rdy_q;
    assign no_act_rdy  = no_act_rdy_q;
    assign cas_rdy     = cas_rdy_q;
    assign pre_rdy     = pre_rdy_q;
    assign prea_rdy    = prea_rdy_q;
    assign refresh_rdy = refresh_rdy_q;
    assign ref_overrun = ref_overrun_q;

endmodule

// File: tb/tb_ctrl_bank_timer.sv
// tb_ctrl_bank_timer: schedule-based model of two bank timers (default and short tREFI) checked every cycle
module tb_ctrl_bank_timer;
    import ctrl_bank_timer_pkg::*;

    localparam int RCD = 11, RP = 11, TWR = 12, RFC = 208;

    logic        CK_t = 1'b0, reset_n = 1'b0, req_valid = 1'b0;
    logic        init [2];
    logic [1:0]  req_type = 2'd0, bg = 2'd0, ba = 2'd0;
    logic [13:0] row = 14'd0;
    logic [4:0]  CL = 5'd11, CWL = 5'd9, AL = 5'd0;
    logic [3:0]  BL = 4'd8;
    wire  [7:0]  o0, o1;

    int cyc = 0, n_chk = 0, n_pass = 0;

    int free_at [2], act_at [2], noact_at [2], cas_at [2], pre_at [2], prea_at [2], ref_at [2];
    int pclr_at [2], acc_at [2], en_cnt [2];
    bit pend [2], ovr [2], acc [2];
    bit opn [2][16];
    logic [13:0] orow [2][16];

    ctrl_bank_timer dut0 (
        .CK_t(CK_t), .reset_n(reset_n), .init_done(init[0]), .req_valid(req_valid),
        .req_type(req_type), .bg_addr(bg), .ba_addr(ba), .row_addr(row),
        .CL(CL), .CWL(CWL), .AL(AL), .BL(BL),
        .busy(o0[7]), .act_rdy(o0[6]), .no_act_rdy(o0[5]), .cas_rdy(o0[4]),
        .pre_rdy(o0[3]), .prea_rdy(o0[2]), .refresh_rdy(o0[1]), .ref_overrun(o0[0])
    );

    ctrl_bank_timer #(.tREFI(100)) dut1 (
        .CK_t(CK_t), .reset_n(reset_n), .init_done(init[1]), .req_valid(req_valid),
        .req_type(req_type), .bg_addr(bg), .ba_addr(ba), .row_addr(row),
        .CL(CL), .CWL(CWL), .AL(AL), .BL(BL),
        .busy(o1[7]), .act_rdy(o1[6]), .no_act_rdy(o1[5]), .cas_rdy(o1[4]),
        .pre_rdy(o1[3]), .prea_rdy(o1[2]), .refresh_rdy(o1[1]), .ref_overrun(o1[0])
    );

    always #5 CK_t = ~CK_t;
    always @(posedge CK_t) cyc <= cyc + 1;

    function automatic void chk(string nm, int got, int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, got, want);
    endfunction

    function automatic void mreset(int d);
        free_at[d] = 0; act_at[d] = -1; noact_at[d] = -1; cas_at[d] = -1; pre_at[d] = -1;
        prea_at[d] = -1; ref_at[d] = -1; pclr_at[d] = -1; en_cnt[d] = 0;
        pend[d] = 0; ovr[d] = 0;
        for (int b = 0; b < 16; b++) opn[d][b] = 0;
    endfunction

    function automatic logic [7:0] expect_out(int d);
        int n = cyc;
        if (!reset_n) return {!init[d], 7'b0};
        return {!init[d] || n < free_at[d] || pend[d], n == act_at[d], n == noact_at[d],
                n == cas_at[d], n == pre_at[d], n == prea_at[d], n == ref_at[d], ovr[d]};
    endfunction

    // Advance the model by the inputs seen in the current cycle: decide what
    // starts now and record the absolute cycles of every resulting pulse.
    function automatic void step(int d);
        int n = cyc;
        int b, lat;
        bit ex, ap, any;
        acc[d] = 0;
        if (!reset_n) begin
            mreset(d);
            return;
        end
        if (n >= free_at[d] && pend[d]) begin
            any = 0;
            for (int k = 0; k < 16; k++) any |= opn[d][k];
            if (any) begin
                prea_at[d] = n + 1;
                ref_at[d]  = n + 1 + RP;
                for (int k = 0; k < 16; k++) opn[d][k] = 0;
            end else ref_at[d] = n + 1;
            free_at[d] = ref_at[d] + RFC;
            pclr_at[d] = free_at[d];
        end else if (n >= free_at[d] && init[d] && req_valid) begin
            b   = {bg, ba};
            ap  = req_type == RDA_R || req_type == WRA_R;
            lat = AL + ((req_type == WR_R || req_type == WRA_R) ? CWL + TWR : CL) + BL / 2;
            if (!opn[d][b]) begin
                act_at[d] = n + 1;
                cas_at[d] = n + 1 + RCD;
            end else if (orow[d][b] == row) begin
                noact_at[d] = n + 1;
                cas_at[d]   = n + 2;
            end else begin
                pre_at[d] = n + 1;
                act_at[d] = n + 1 + RP;
                cas_at[d] = act_at[d] + RCD;
            end
            opn[d][b]  = !ap;
            orow[d][b] = row;
            free_at[d] = cas_at[d] + lat + (ap ? RP : 0);
            acc[d]     = 1;
            acc_at[d]  = n;
        end
        ex = 0;
        if (init[d]) begin
            ex = (en_cnt[d] % ((d ? 100 : 6240) + 1)) == (d ? 100 : 6240);
            en_cnt[d]++;
        end
        if (ex && pend[d]) ovr[d] = 1;
        pend[d] = ex || (pend[d] && n + 1 != pclr_at[d]);
    endfunction

    always @(negedge CK_t) begin
        for (int d = 0; d < 2; d++) begin
            logic [7:0] e, a;
            e = expect_out(d);
            a = d ? o1 : o0;
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL dut%0d outputs cyc %0d: got %b, want %b (busy act noact cas pre prea ref ovr)", d, cyc, a, e);
            step(d);
        end
    end

    task automatic tick(int k);
        repeat (k) @(posedge CK_t);
        #1;
    endtask

    task automatic issue(int d, request_type t, logic [1:0] g, logic [1:0] a, logic [13:0] r, bit wait_idle);
        int w = 0;
        req_valid = 1'b1; req_type = t; bg = g; ba = a; row = r;
        do begin tick(1); w++; end while (!acc[d] && w < 600);
        if (!acc[d]) chk("accept timeout", w, -1);
        req_valid = 1'b0;
        w = 0;
        while (wait_idle && cyc < free_at[d] && w < 2000) begin tick(1); w++; end
        if (wait_idle && cyc < free_at[d]) chk("idle timeout", w, -1);
    endtask

    initial begin
        int w;
        init[0] = 1'b0; init[1] = 1'b0;
        mreset(0); mreset(1);
        tick(3);
        chk("busy in reset", o0[7], 1);
        chk("no pulse in reset", o0[6:1], 0);
        reset_n = 1'b1;
        tick(2);
        init[0] = 1'b1;
        tick(2);

        issue(0, RD_R, 2'd0, 2'd1, 14'h123, 1);
        chk("closed act", act_at[0] - acc_at[0], 1);
        chk("closed cas", cas_at[0] - acc_at[0], 12);
        chk("closed rd idle", free_at[0] - acc_at[0], 27);

        issue(0, WR_R, 2'd0, 2'd1, 14'h123, 1);
        chk("hit noact", noact_at[0] - acc_at[0], 1);
        chk("hit cas", cas_at[0] - acc_at[0], 2);
        chk("hit wr idle", free_at[0] - acc_at[0], 27);

        issue(0, RD_R, 2'd0, 2'd1, 14'h200, 1);
        chk("miss pre", pre_at[0] - acc_at[0], 1);
        chk("miss act", act_at[0] - acc_at[0], 12);
        chk("miss cas", cas_at[0] - acc_at[0], 23);
        chk("miss idle", free_at[0] - acc_at[0], 38);

        issue(0, RDA_R, 2'd0, 2'd1, 14'h200, 1);
        chk("rda idle", free_at[0] - acc_at[0], 28);
        issue(0, RD_R, 2'd0, 2'd1, 14'h200, 1);
        chk("after rda act", act_at[0] - acc_at[0], 1);

        AL = 5'd2; CL = 5'd13; BL = 4'd4;
        issue(0, RD_R, 2'd0, 2'd3, 14'd9, 1);
        chk("latency mix idle", free_at[0] - acc_at[0], 29);
        AL = 5'd0; CL = 5'd11; BL = 4'd8;

        issue(0, WRA_R, 2'd3, 2'd2, 14'h3fff, 1);
        chk("wra idle", free_at[0] - acc_at[0], 48);
        issue(0, RD_R, 2'd3, 2'd2, 14'h3fff, 1);
        chk("after wra act", act_at[0] - acc_at[0], 1);

        issue(0, RD_R, 2'd1, 2'd1, 14'd5, 0);
        tick(4);
        reset_n = 1'b0; init[0] = 1'b0;
        #1;
        chk("pulses cleared by reset", o0[6:1], 0);
        chk("busy after reset", o0[7], 1);
        tick(3);
        reset_n = 1'b1;
        tick(2);
        init[0] = 1'b1;
        tick(2);
        issue(0, RD_R, 2'd1, 2'd1, 14'd5, 1);
        chk("post reset act", act_at[0] - acc_at[0], 1);
        chk("no overrun dut0", o0[0], 0);

        init[0] = 1'b0;
        init[1] = 1'b1;
        issue(1, RD_R, 2'd2, 2'd0, 14'd7, 1);
        chk("dut1 open act", act_at[1] - acc_at[1], 1);
        w = 0;
        while (!pend[1] && w < 300) begin tick(1); w++; end
        if (!pend[1]) chk("refresh pending timeout", w, -1);
        issue(1, RD_R, 2'd2, 2'd0, 14'd7, 1);
        chk("prea to ref", ref_at[1] - prea_at[1], 11);
        chk("ref to accept", acc_at[1] - ref_at[1], 208);
        chk("post refresh act", act_at[1] - acc_at[1], 1);
        chk("model overrun", ovr[1], 1);
        chk("overrun sticky", o1[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got cycle %0d, want finish", cyc);
        $fatal(1);
    end

endmodule
